shifter_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational Shifter used by the ALU.
- Generalises data width and adds two modes to SLL/SRA: SRL and ROR.
- Splits the barrel shift into log2(WIDTH) registered stages, with a valid/ready handshake, a global stall and a synchronous flush.
- Sits between the EX-stage operand muxes and the multi-cycle writeback path.

---
 rtl/shifter_pipe_if.sv | 29 ++
 rtl/shifter_pipe.sv | 90 +++++++++
 tb/tb_shifter_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_pipe_if.sv
// Handshake bundle for shifter_pipe: operand/shift-amount/mode/tag in, result/tag out.
// The master side is the operand producer and the result consumer; the slave side is the pipeline.
interface shifter_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL): one registered stage per shift-amount bit,
// global stall on output backpressure, synchronous flush and reset.
module shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  shifter_pipe_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int NL      = SHAMT_W + 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  // Layer 0 captures the operand unshifted so the EX operand muxes never feed barrel logic
  // directly; layer k+1 holds the result after shift stage k. Layer NL-1 drives the outputs.
  logic [NL-1:0]      valid_r;
  logic [WIDTH-1:0]   data_r  [NL];
  logic [TAG_W-1:0]   tag_r   [NL];
  logic [SHAMT_W-1:0] shamt_r [SHAMT_W];
  logic [1:0]         mode_r  [SHAMT_W];
  logic [WIDTH-1:0]   step_data_s [SHAMT_W];
  logic               stall_s;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input int               k
  );
    int unsigned amt;
    amt = 32'd1 << k;
    case (mode)
      MODE_SLL: return d << amt;
      MODE_SRA: return $signed(d) >>> amt;
      MODE_ROR: return (d >> amt) | (d << (WIDTH - amt));
      MODE_SRL: return d >> amt;
      default:  return d;
    endcase
  endfunction

  assign stall_s      = valid_r[NL-1] && !bus.out_ready;
  assign bus.in_ready = !stall_s;
  assign bus.out_valid = valid_r[NL-1];
  assign bus.out_data  = data_r[NL-1];
  assign bus.out_tag   = tag_r[NL-1];

  // Shift stage k consumes bit 0 of the remaining shift amount held in layer k.
  always_comb begin
    for (int k = 0; k < SHAMT_W; k++) begin
      step_data_s[k] = shamt_r[k][0] ? shift_step(data_r[k], mode_r[k], k) : data_r[k];
    end
  end

  // Pipeline registers: reset clears everything, flush drops valids, stall freezes all layers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < NL; i++) begin
        data_r[i] <= '0;
        tag_r[i]  <= '0;
      end
      for (int i = 0; i < SHAMT_W; i++) begin
        shamt_r[i] <= '0;
        mode_r[i]  <= 2'b00;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else if (!stall_s) begin
      valid_r[0] <= bus.in_valid;
      data_r[0]  <= bus.in_data;
      tag_r[0]   <= bus.in_tag;
      shamt_r[0] <= bus.in_shamt;
      mode_r[0]  <= bus.in_mode;
      for (int k = 0; k < SHAMT_W; k++) begin
        valid_r[k+1] <= valid_r[k];
        data_r[k+1]  <= step_data_s[k];
        tag_r[k+1]   <= tag_r[k];
      end
      for (int k = 0; k < SHAMT_W - 1; k++) begin
        shamt_r[k+1] <= shamt_r[k] >> 1'b1;
        mode_r[k+1]  <= mode_r[k];
      end
    end
  end
endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe at WIDTH=16 and WIDTH=32 against a queue-based reference.
module tb_shifter_pipe;
  localparam int LAT16 = 4;
  localparam int LAT32 = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  shifter_pipe_if #(.WIDTH(16), .TAG_W(4)) b16 ();
  shifter_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();

  shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (.clk(clk), .rst(rst), .flush(flush), .bus(b16));
  shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    int          acc;
    int          stl;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int   cyc   = 0;
  int   stl16 = 0;
  logic prev_stall16 = 1'b0;
  logic [15:0] prev_data16;
  logic [3:0]  prev_tag16;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference operators on a w-bit value held in 64 bits.
  function automatic logic [63:0] ref_op(input logic [63:0] d_in, input int sh,
                                         input logic [1:0] m, input int w);
    logic [63:0] mask, d, r;
    mask = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    d = d_in & mask;
    case (m)
      2'b00: r = (d << sh) & mask;
      2'b01: begin
        r = d >> sh;
        if (d[w-1]) r = r | (mask & ~(mask >> sh));
      end
      2'b10: r = (sh == 0) ? d : (((d >> sh) | (d << (w - sh))) & mask);
      default: r = d >> sh;
    endcase
    return r;
  endfunction

  // Scoreboards: decide at the negedge what the next posedge will accept/retire.
  always @(negedge clk) begin
    exp_t e;
    logic st;
    cyc++;
    if (rst) begin
      q16.delete();
      q32.delete();
      prev_stall16 = 1'b0;
    end else begin
      check("in_ready16", b16.in_ready, !(b16.out_valid && !b16.out_ready));
      check("in_ready32", b32.in_ready, !(b32.out_valid && !b32.out_ready));
      if (b16.in_valid) check("mode_known16", $isunknown(b16.in_mode), 1'b0);
      if (prev_stall16) begin
        check("hold_valid16", b16.out_valid, 1'b1);
        check("hold_data16", b16.out_data, prev_data16);
        check("hold_tag16", b16.out_tag, prev_tag16);
      end
      if (q16.size() == 0) check("no_pending_valid16", b16.out_valid, 1'b0);
      if (q32.size() == 0) check("no_pending_valid32", b32.out_valid, 1'b0);
      if (b16.out_valid && b16.out_ready && q16.size() > 0) begin
        e = q16.pop_front();
        check("data16", b16.out_data, e.data);
        check("tag16", b16.out_tag, e.tag);
        check("latency16", cyc, e.acc + LAT16 + 1 + (stl16 - e.stl));
      end
      if (b32.out_valid && b32.out_ready && q32.size() > 0) begin
        e = q32.pop_front();
        check("data32", b32.out_data, e.data);
        check("tag32", b32.out_tag, e.tag);
      end
      st = b16.out_valid && !b16.out_ready;
      if (st) stl16++;
      prev_stall16 = st && !flush;
      prev_data16  = b16.out_data;
      prev_tag16   = b16.out_tag;
      if (flush) begin
        q16.delete();
        q32.delete();
      end else begin
        if (b16.in_valid && b16.in_ready) begin
          e.data = ref_op({48'd0, b16.in_data}, int'(b16.in_shamt), b16.in_mode, 16);
          e.tag = b16.in_tag; e.acc = cyc; e.stl = stl16;
          q16.push_back(e);
        end
        if (b32.in_valid && b32.in_ready) begin
          e.data = ref_op({32'd0, b32.in_data}, int'(b32.in_shamt), b32.in_mode, 32);
          e.tag = b32.in_tag; e.acc = cyc; e.stl = 0;
          q32.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one16(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] m,
                           input logic [3:0] tg, input logic [15:0] exp, input string name);
    int lat;
    lat = 0;
    b16.in_valid = 1'b1; b16.in_data = d; b16.in_shamt = sh; b16.in_mode = m; b16.in_tag = tg;
    b16.out_ready = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b16.out_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_lat"}, lat, LAT16);
    check(name, b16.out_data, exp);
    check({name, "_tag"}, b16.out_tag, tg);
    tick();
  endtask

  task automatic run_one32(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                           input logic [31:0] exp, input string name);
    int lat;
    lat = 0;
    b32.in_valid = 1'b1; b32.in_data = d; b32.in_shamt = sh; b32.in_mode = m; b32.in_tag = 4'd9;
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b32.out_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_lat"}, lat, LAT32);
    check(name, b32.out_data, exp);
    tick();
  endtask

  task automatic drain();
    b16.in_valid = 1'b0; b32.in_valid = 1'b0;
    b16.out_ready = 1'b1; b32.out_ready = 1'b1; flush = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dd [12];
    logic [3:0]  ds [12];
    logic [1:0]  dm [12];
    logic [15:0] de [12];
    logic        fire;
    int          i;
    int          k;

    dd = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FF0, 16'h8000, 16'h1234,
           16'h0001, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h8001};
    ds = '{4'd15, 4'd4, 4'd15, 4'd4, 4'd15, 4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    dm = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    de = '{16'h8000, 16'hFFF0, 16'hFFFF, 16'h07FF, 16'h0001, 16'h4123,
           16'h8000, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0003};

    rst = 1'b1; flush = 1'b0;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_shamt = '0; b16.in_mode = 2'b00;
    b16.in_tag = '0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_shamt = '0; b32.in_mode = 2'b00;
    b32.in_tag = '0; b32.out_ready = 1'b1;
    repeat (3) tick();
    check("reset_out_valid", b16.out_valid, 1'b0);
    check("reset_out_data", b16.out_data, 16'h0000);
    rst = 1'b0;
    tick();
    check("reset_in_ready", b16.in_ready, 1'b1);

    check("model_ror32", ref_op(64'h80000001, 1, 2'b10, 32), 64'hC0000000);
    check("model_sra16", ref_op(64'h8000, 15, 2'b01, 16), 64'hFFFF);

    for (int n = 0; n < 12; n++) run_one16(dd[n], ds[n], dm[n], n[3:0], de[n], $sformatf("dir%0d", n));
    run_one32(32'h80000001, 5'd1, 2'b10, 32'hC0000000, "ror32");
    run_one32(32'h80000000, 5'd31, 2'b01, 32'hFFFFFFFF, "sra32");

    // Backpressure: 8 tagged ops, out_ready low for 3 cycles mid-stream.
    i = 0; k = 0;
    b16.in_data = 16'($urandom); b16.in_shamt = 4'($urandom); b16.in_mode = 2'($urandom);
    while ((i < 8 || q16.size() > 0) && k < 60) begin
      b16.in_valid = (i < 8);
      b16.in_tag = i[3:0];
      b16.out_ready = !(k >= 6 && k < 9);
      @(negedge clk);
      fire = b16.in_valid && b16.in_ready;
      tick();
      if (fire) begin
        i++;
        b16.in_data = 16'($urandom); b16.in_shamt = 4'($urandom); b16.in_mode = 2'($urandom);
      end
      k++;
    end
    check("bp_all_retired", q16.size(), 0);
    check("bp_all_accepted", i, 8);
    drain();

    // Flush with 3 ops in flight and a fourth presented in the same cycle.
    for (int n = 0; n < 4; n++) begin
      b16.in_valid = 1'b1; b16.in_data = 16'h00FF; b16.in_shamt = 4'd3;
      b16.in_mode = 2'b00; b16.in_tag = n[3:0];
      flush = (n == 3);
      tick();
    end
    flush = 1'b0; b16.in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check("flush_no_valid", b16.out_valid, 1'b0);
      tick();
    end
    run_one16(16'h00F0, 4'd2, 2'b00, 4'd5, 16'h03C0, "post_flush");

    // Reset in the middle of a stalled stream.
    b16.out_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      b16.in_valid = 1'b1; b16.in_data = 16'hA5A5; b16.in_shamt = 4'd1;
      b16.in_mode = 2'b11; b16.in_tag = 4'd3;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; b16.in_valid = 1'b0;
    check("midrst_out_valid", b16.out_valid, 1'b0);
    check("midrst_out_data", b16.out_data, 16'h0000);
    check("midrst_out_tag", b16.out_tag, 4'h0);
    check("midrst_in_ready", b16.in_ready, 1'b1);
    drain();

    // Random regression, WIDTH=16.
    for (int n = 0; n < 4000; n++) begin
      b16.in_valid = ($urandom_range(3) != 0);
      b16.in_data = 16'($urandom); b16.in_shamt = 4'($urandom);
      b16.in_mode = 2'($urandom); b16.in_tag = 4'($urandom);
      b16.out_ready = ($urandom_range(4) != 0);
      flush = ($urandom_range(149) == 0);
      tick();
    end
    drain();
    check("rand16_drained", q16.size(), 0);

    // Random regression, WIDTH=32.
    for (int n = 0; n < 3000; n++) begin
      b32.in_valid = ($urandom_range(3) != 0);
      b32.in_data = $urandom; b32.in_shamt = 5'($urandom);
      b32.in_mode = 2'($urandom); b32.in_tag = 4'($urandom);
      b32.out_ready = ($urandom_range(4) != 0);
      flush = ($urandom_range(199) == 0);
      tick();
    end
    drain();
    check("rand32_drained", q32.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
